// File: rtl/rewind_queue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rewind_pkg : shared types for the rewind_queue store undo buffer
// Rev 1.0
// ---------------------------------------------------------------------------
package rewind_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } rewind_state_e;

   // Cache operation codes shared with the L1 data cache.
   localparam logic [2:0] NO_OP = 3'd0;
   localparam logic [2:0] LD    = 3'd1;
   localparam logic [2:0] ST    = 3'd2;
   localparam logic [2:0] RD    = 3'd3;
   localparam logic [2:0] WR    = 3'd4;
   localparam logic [2:0] INV   = 3'd5;
   localparam logic [2:0] UPD   = 3'd6;
   localparam logic [2:0] WR_LD = 3'd7;

   localparam int ENTRY_ADDR_W = 32;
   localparam int ENTRY_DATA_W = 32;
   localparam int ENTRY_TAG_W  = 10;

   // Entry layout for the default configuration.
   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] addr;
      logic [ENTRY_DATA_W-1:0] data;
      logic [1:0]              size;
      logic [ENTRY_TAG_W-1:0]  tag;
   } rewind_entry_t;

endpackage
`default_nettype wire

// File: rtl/rewind_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rewind_queue_if : cache-side alloc and replay handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface rewind_queue_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 10
) ();
   logic              alloc_valid;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] data_repl;
   logic [1:0]        size_in;
   logic [TAG_W-1:0]  cache_ooo_tag_in;
   logic              rewind_full;
   logic              rewind_busy;
   logic              valid_rewind;
   logic              rewind_ready;
   logic [ADDR_W-1:0] addr_out;
   logic [DATA_W-1:0] data_out;
   logic [1:0]        size_out;
   logic [TAG_W-1:0]  cache_ooo_tag_out;

   // master = cache, slave = rewind queue
   modport master (
      output alloc_valid, addr_in, data_repl, size_in, cache_ooo_tag_in, rewind_ready,
      input  rewind_full, rewind_busy, valid_rewind,
             addr_out, data_out, size_out, cache_ooo_tag_out
   );

   modport slave (
      input  alloc_valid, addr_in, data_repl, size_in, cache_ooo_tag_in, rewind_ready,
      output rewind_full, rewind_busy, valid_rewind,
             addr_out, data_out, size_out, cache_ooo_tag_out
   );
endinterface
`default_nettype wire

// File: rtl/rewind_queue_tag_cam.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rewind_tag_cam : DEPTH-wide tag compare producing the retire match vector
// Rev 1.0
// ---------------------------------------------------------------------------
module rewind_tag_cam
   import rewind_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAG_W = 10
) (
   input  logic [DEPTH-1:0][TAG_W-1:0] tags,
   input  logic [DEPTH-1:0]            entry_vld,
   input  logic [TAG_W-1:0]            key,
   input  logic                        key_vld,
   output logic [DEPTH-1:0]            match
);
   for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign match[i] = key_vld && entry_vld[i] && (tags[i] == key);
   end
endmodule
`default_nettype wire

// File: rtl/rewind_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rewind_queue : speculative-store undo buffer, youngest-first replay on resteer
// Optional macro REWIND_REPLAY_CNT_EN adds a saturating replay handshake count.
// Rev 1.0
// ---------------------------------------------------------------------------
module rewind_queue
   import rewind_pkg::*;
#(
   parameter int OOO_TAG_SIZE = 10,
   parameter int DEPTH        = 8,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [OOO_TAG_SIZE-1:0]      rob_ret_tag_in,
   input  logic                         rob_valid,
   input  logic                         rob_resteer,
   rewind_queue_if.slave                bus,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef REWIND_REPLAY_CNT_EN
   ,
   output logic [15:0]                  rewind_replay_cnt
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_W-1:0]       addr;
      logic [DATA_W-1:0]       data;
      logic [1:0]              size;
      logic [OOO_TAG_SIZE-1:0] tag;
   } entry_t;

   rewind_state_e state_q, state_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [DEPTH-1:0] ret_q, ret_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           entry_q [DEPTH];
   entry_t           entry_d [DEPTH];

   logic [DEPTH-1:0][OOO_TAG_SIZE-1:0] tag_vec;
   logic [DEPTH-1:0] ret_match;
   logic [PTR_W-1:0] last_idx;
   logic [PTR_W-1:0] next_last;
   logic             full;
   logic             alloc_fire;
   logic             drain_fire;
   logic             pop_fire;
   logic             valid_rewind;

   for (genvar i = 0; i < DEPTH; i++) begin : g_tag
      assign tag_vec[i] = entry_q[i].tag;
   end

   rewind_tag_cam #(
      .DEPTH (DEPTH),
      .TAG_W (OOO_TAG_SIZE)
   ) u_cam (
      .tags      (tag_vec),
      .entry_vld (vld_q),
      .key       (rob_ret_tag_in),
      .key_vld   (rob_valid),
      .match     (ret_match)
   );

   assign last_idx     = tail_q - PTR_W'(1);
   assign full         = (count_q == CNT_W'(DEPTH));
   // A retired tail-1 ends the replay, so it is never presented.
   assign valid_rewind = (state_q == REPLAY) && vld_q[last_idx] && !ret_q[last_idx];
   assign pop_fire     = valid_rewind && bus.rewind_ready;
   assign alloc_fire   = bus.alloc_valid && !full && (state_q == IDLE);
   assign drain_fire   = (state_q == IDLE) && vld_q[head_q] && ret_q[head_q];

   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      vld_d     = vld_q;
      entry_d   = entry_q;
      next_last = '0;
      // Retire is applied first so a same-cycle resteer excludes it.
      ret_d     = ret_q | ret_match;

      if (drain_fire) begin
         vld_d[head_q] = 1'b0;
         ret_d[head_q] = 1'b0;
         head_d        = head_q + PTR_W'(1);
      end

      if (alloc_fire) begin
         vld_d[tail_q]        = 1'b1;
         ret_d[tail_q]        = 1'b0;
         entry_d[tail_q].addr = bus.addr_in;
         entry_d[tail_q].data = bus.data_repl;
         entry_d[tail_q].size = bus.size_in;
         entry_d[tail_q].tag  = bus.cache_ooo_tag_in;
         tail_d               = tail_q + PTR_W'(1);
      end

      if (pop_fire) begin
         vld_d[last_idx] = 1'b0;
         ret_d[last_idx] = 1'b0;
         tail_d          = last_idx;
      end

      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(drain_fire) - CNT_W'(pop_fire);

      next_last = tail_d - PTR_W'(1);
      case (state_q)
         IDLE: begin
            if (rob_resteer && (|(vld_d & ~ret_d)))
               state_d = REPLAY;
         end
         REPLAY: begin
            if (!(vld_d[next_last] && !ret_d[next_last]))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         vld_q   <= '0;
         ret_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         vld_q   <= vld_d;
         ret_q   <= ret_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: every read is qualified by vld.
   always_ff @(posedge clk) begin
      entry_q <= entry_d;
   end

   assign bus.rewind_full       = full;
   assign bus.rewind_busy       = (state_q == REPLAY);
   assign bus.valid_rewind      = valid_rewind;
   assign bus.addr_out          = valid_rewind ? entry_q[last_idx].addr : '0;
   assign bus.data_out          = valid_rewind ? entry_q[last_idx].data : '0;
   assign bus.size_out          = valid_rewind ? entry_q[last_idx].size : '0;
   assign bus.cache_ooo_tag_out = valid_rewind ? entry_q[last_idx].tag  : '0;
   assign count                 = count_q;

`ifdef REWIND_REPLAY_CNT_EN
   logic [15:0] replay_cnt_q, replay_cnt_d;

   always_comb begin
      replay_cnt_d = replay_cnt_q;
      if (pop_fire && (replay_cnt_q != 16'hFFFF))
         replay_cnt_d = replay_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         replay_cnt_q <= '0;
      else
         replay_cnt_q <= replay_cnt_d;
   end

   assign rewind_replay_cnt = replay_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rewind_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rewind_queue : directed self-checking bench for rewind_queue
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rewind_queue;
   logic       clk;
   logic       rst;
   logic [9:0] rob_ret_tag_in;
   logic       rob_valid;
   logic       rob_resteer;
   logic [3:0] count;
`ifdef REWIND_REPLAY_CNT_EN
   logic [15:0] rewind_replay_cnt;
`endif

   int errors;
   int checks;

   rewind_queue_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(10)) bus ();

   rewind_queue #(
      .OOO_TAG_SIZE (10),
      .DEPTH        (8),
      .ADDR_W       (32),
      .DATA_W       (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rob_ret_tag_in (rob_ret_tag_in),
      .rob_valid      (rob_valid),
      .rob_resteer    (rob_resteer),
      .bus            (bus),
      .count          (count)
`ifdef REWIND_REPLAY_CNT_EN
      ,
      .rewind_replay_cnt (rewind_replay_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] data_of(input logic [9:0] tag);
      return 32'hD000_0000 | 32'(tag);
   endfunction

   task automatic do_alloc(input logic [9:0] tag);
      bus.alloc_valid      = 1'b1;
      bus.addr_in          = 32'h1000_0000 | 32'(tag);
      bus.data_repl        = data_of(tag);
      bus.size_in          = tag[1:0];
      bus.cache_ooo_tag_in = tag;
      step();
      bus.alloc_valid      = 1'b0;
   endtask

   task automatic do_retire(input logic [9:0] tag);
      rob_valid      = 1'b1;
      rob_ret_tag_in = tag;
      step();
      rob_valid      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (count !== 4'd0 || bus.rewind_full !== 1'b0 || bus.rewind_busy !== 1'b0 ||
          bus.valid_rewind !== 1'b0 || bus.data_out !== 32'd0 || bus.addr_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: count=%0d full=%b busy=%b vr=%b data=%h addr=%h required all 0",
                  count, bus.rewind_full, bus.rewind_busy, bus.valid_rewind, bus.data_out, bus.addr_out);
      end
      #2 rst = 1'b0;
      step();
   endtask

   task automatic test_retire_drain();
      logic       saw_vr;
      logic [3:0] exp_cnt [4];
      exp_cnt = '{4'd3, 4'd2, 4'd1, 4'd0};
      saw_vr  = 1'b0;
      do_alloc(10'd1);
      do_alloc(10'd2);
      do_alloc(10'd3);
      checks++;
      if (count !== 4'd3) begin
         errors++;
         $display("FAIL alloc_count: count=%0d required 3", count);
      end
      for (int i = 0; i < 4; i++) begin
         if (i < 3) do_retire(10'(i + 1));
         else step();
         saw_vr |= bus.valid_rewind;
         checks++;
         if (count !== exp_cnt[i]) begin
            errors++;
            $display("FAIL drain_count[%0d]: count=%0d required %0d", i, count, exp_cnt[i]);
         end
      end
      checks++;
      if (saw_vr !== 1'b0) begin
         errors++;
         $display("FAIL drain_no_replay: valid_rewind seen=%b required 0", saw_vr);
      end
   endtask

   task automatic test_replay();
      do_alloc(10'd4);
      do_alloc(10'd5);
      do_alloc(10'd6);
      do_retire(10'd4);
      rob_resteer = 1'b1;
      step();
      rob_resteer = 1'b0;
      checks++;
      if (bus.valid_rewind !== 1'b1 || bus.cache_ooo_tag_out !== 10'd6 ||
          bus.data_out !== data_of(10'd6) || count !== 4'd2 || bus.rewind_busy !== 1'b1) begin
         errors++;
         $display("FAIL replay_first: vr=%b tag=%0d data=%h count=%0d busy=%b required 1/6/%h/2/1",
                  bus.valid_rewind, bus.cache_ooo_tag_out, bus.data_out, count, bus.rewind_busy, data_of(10'd6));
      end
      step();
      checks++;
      if (bus.valid_rewind !== 1'b1 || bus.cache_ooo_tag_out !== 10'd5 ||
          bus.data_out !== data_of(10'd5) || count !== 4'd1) begin
         errors++;
         $display("FAIL replay_second: vr=%b tag=%0d data=%h count=%0d required 1/5/%h/1",
                  bus.valid_rewind, bus.cache_ooo_tag_out, bus.data_out, count, data_of(10'd5));
      end
      step();
      checks++;
      if (bus.valid_rewind !== 1'b0 || bus.rewind_busy !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL replay_done: vr=%b busy=%b count=%0d required 0/0/0",
                  bus.valid_rewind, bus.rewind_busy, count);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) do_alloc(10'(10 + i));
      checks++;
      if (bus.rewind_full !== 1'b1 || count !== 4'd8) begin
         errors++;
         $display("FAIL fill: full=%b count=%0d required 1/8", bus.rewind_full, count);
      end
      do_alloc(10'd18);
      checks++;
      if (bus.rewind_full !== 1'b1 || count !== 4'd8) begin
         errors++;
         $display("FAIL overflow_drop: full=%b count=%0d required 1/8", bus.rewind_full, count);
      end
      do_retire(10'd10);
      checks++;
      if (bus.rewind_full !== 1'b1) begin
         errors++;
         $display("FAIL full_after_mark: full=%b required 1", bus.rewind_full);
      end
      step();
      checks++;
      if (bus.rewind_full !== 1'b0 || count !== 4'd7) begin
         errors++;
         $display("FAIL full_clear: full=%b count=%0d required 0/7", bus.rewind_full, count);
      end
      for (int i = 11; i < 18; i++) do_retire(10'(i));
      step();
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL full_empty: count=%0d required 0", count);
      end
   endtask

   task automatic test_stall();
      do_alloc(10'd20);
      do_alloc(10'd21);
      bus.rewind_ready = 1'b0;
      rob_resteer = 1'b1;
      step();
      rob_resteer = 1'b0;
      bus.alloc_valid      = 1'b1;
      bus.cache_ooo_tag_in = 10'd99;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.valid_rewind !== 1'b1 || bus.cache_ooo_tag_out !== 10'd21 ||
             bus.data_out !== data_of(10'd21) || bus.addr_out !== 32'h1000_0015 || count !== 4'd2) begin
            errors++;
            $display("FAIL stall_hold[%0d]: vr=%b tag=%0d data=%h addr=%h count=%0d required 1/21/%h/10000015/2",
                     i, bus.valid_rewind, bus.cache_ooo_tag_out, bus.data_out, bus.addr_out, count, data_of(10'd21));
         end
      end
      bus.alloc_valid  = 1'b0;
      bus.rewind_ready = 1'b1;
      step();
      checks++;
      if (bus.cache_ooo_tag_out !== 10'd20 || count !== 4'd1) begin
         errors++;
         $display("FAIL stall_resume: tag=%0d count=%0d required 20/1", bus.cache_ooo_tag_out, count);
      end
      step();
      checks++;
      if (bus.rewind_busy !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL stall_done: busy=%b count=%0d required 0/0", bus.rewind_busy, count);
      end
   endtask

   task automatic test_wrap();
      logic [9:0] exp_tag [4];
      exp_tag = '{10'd43, 10'd42, 10'd41, 10'd40};
      // Move head and tail from index 4 to index 6.
      do_alloc(10'd30);
      do_alloc(10'd31);
      do_retire(10'd30);
      do_retire(10'd31);
      step();
      for (int i = 0; i < 4; i++) do_alloc(10'(40 + i));
      rob_resteer = 1'b1;
      step();
      rob_resteer = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.valid_rewind !== 1'b1 || bus.cache_ooo_tag_out !== exp_tag[i] ||
             bus.data_out !== data_of(exp_tag[i])) begin
            errors++;
            $display("FAIL wrap_order[%0d]: vr=%b tag=%0d data=%h required 1/%0d/%h",
                     i, bus.valid_rewind, bus.cache_ooo_tag_out, bus.data_out, exp_tag[i], data_of(exp_tag[i]));
         end
         step();
      end
      checks++;
      if (bus.rewind_busy !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL wrap_done: busy=%b count=%0d required 0/0", bus.rewind_busy, count);
      end
   endtask

   task automatic test_same_cycle();
      do_alloc(10'd50);
      do_alloc(10'd51);
      rob_valid      = 1'b1;
      rob_ret_tag_in = 10'd50;
      rob_resteer    = 1'b1;
      step();
      rob_valid   = 1'b0;
      rob_resteer = 1'b0;
      checks++;
      if (bus.valid_rewind !== 1'b1 || bus.cache_ooo_tag_out !== 10'd51 || count !== 4'd2) begin
         errors++;
         $display("FAIL retire_resteer: vr=%b tag=%0d count=%0d required 1/51/2",
                  bus.valid_rewind, bus.cache_ooo_tag_out, count);
      end
      step();
      checks++;
      if (bus.rewind_busy !== 1'b0 || count !== 4'd1) begin
         errors++;
         $display("FAIL retire_resteer_end: busy=%b count=%0d required 0/1", bus.rewind_busy, count);
      end
      step();
      do_alloc(10'd52);
      rob_valid      = 1'b1;
      rob_ret_tag_in = 10'd52;
      rob_resteer    = 1'b1;
      step();
      rob_valid   = 1'b0;
      rob_resteer = 1'b0;
      checks++;
      if (bus.rewind_busy !== 1'b0 || bus.valid_rewind !== 1'b0) begin
         errors++;
         $display("FAIL resteer_noop: busy=%b vr=%b required 0/0", bus.rewind_busy, bus.valid_rewind);
      end
      step();
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL resteer_noop_drain: count=%0d required 0", count);
      end
   endtask

   task automatic test_mid_retire();
      do_alloc(10'd60);
      do_alloc(10'd61);
      do_alloc(10'd62);
      rob_resteer = 1'b1;
      step();
      rob_resteer = 1'b0;
      rob_valid      = 1'b1;
      rob_ret_tag_in = 10'd61;
      step();
      rob_valid = 1'b0;
      checks++;
      if (bus.rewind_busy !== 1'b0 || bus.valid_rewind !== 1'b0 || count !== 4'd2) begin
         errors++;
         $display("FAIL mid_retire_stop: busy=%b vr=%b count=%0d required 0/0/2",
                  bus.rewind_busy, bus.valid_rewind, count);
      end
      do_retire(10'd60);
      step();
      step();
      checks++;
      if (count !== 4'd0) begin
         errors++;
         $display("FAIL mid_retire_drain: count=%0d required 0", count);
      end
   endtask

   task automatic test_reset_mid_replay();
      do_alloc(10'd70);
      do_alloc(10'd71);
      bus.rewind_ready = 1'b0;
      rob_resteer = 1'b1;
      step();
      rob_resteer = 1'b0;
      checks++;
      if (bus.rewind_busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_busy: busy=%b required 1", bus.rewind_busy);
      end
`ifdef REWIND_REPLAY_CNT_EN
      checks++;
      if (rewind_replay_cnt !== 16'd10) begin
         errors++;
         $display("FAIL replay_cnt: cnt=%0d required 10", rewind_replay_cnt);
      end
`endif
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rewind_busy !== 1'b0 || bus.valid_rewind !== 1'b0 || count !== 4'd0 ||
          bus.rewind_full !== 1'b0 || bus.data_out !== 32'd0 || bus.cache_ooo_tag_out !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid_replay: busy=%b vr=%b count=%0d full=%b data=%h tag=%0d required all 0",
                  bus.rewind_busy, bus.valid_rewind, count, bus.rewind_full, bus.data_out, bus.cache_ooo_tag_out);
      end
`ifdef REWIND_REPLAY_CNT_EN
      checks++;
      if (rewind_replay_cnt !== 16'd0) begin
         errors++;
         $display("FAIL replay_cnt_reset: cnt=%0d required 0", rewind_replay_cnt);
      end
`endif
      #1 rst = 1'b0;
      bus.rewind_ready = 1'b1;
      step();
      checks++;
      if (count !== 4'd0 || bus.rewind_busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: count=%0d busy=%b required 0/0", count, bus.rewind_busy);
      end
   endtask

   initial begin
      errors               = 0;
      checks               = 0;
      rst                  = 1'b1;
      rob_ret_tag_in       = '0;
      rob_valid            = 1'b0;
      rob_resteer          = 1'b0;
      bus.alloc_valid      = 1'b0;
      bus.addr_in          = '0;
      bus.data_repl        = '0;
      bus.size_in          = '0;
      bus.cache_ooo_tag_in = '0;
      bus.rewind_ready     = 1'b1;

      test_reset();
      test_retire_drain();
      test_replay();
      test_full();
      test_stall();
      test_wrap();
      test_same_cycle();
      test_mid_retire();
      test_reset_mid_replay();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
